// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM bus responder: bus widths, counter width,
// bus cycle types and small helpers used by the responder and its read pipeline.
package sram_responder_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_DEPTH  = 4096;
  localparam int CNT_W       = 16;

  // Encoded as {Write_Signal_n, Read_Signal_n}, so a lone low strobe names the cycle.
  typedef enum logic [1:0] {
    CYC_CONFLICT = 2'b00,
    CYC_WRITE    = 2'b01,
    CYC_READ     = 2'b10,
    CYC_IDLE     = 2'b11
  } cycle_t;

  function automatic cycle_t decode_cycle(input logic read_n, input logic write_n);
    return cycle_t'({write_n, read_n});
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: LAT stages of valid/data. Reset clears the valid bits only,
// which is enough to stop any pending read from ever reaching the bus.
module sram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LAT-1:0]    valid_q;
  logic [DATA_W-1:0] data_q [LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the value its predecessor held before this edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // NOTE: data stages carry no reset; they are qualified by valid_q, and leaving
  // them unreset keeps them plain datapath flops.
  always_ff @(posedge Clock) begin
    data_q[0] <= in_data;
    for (int i = 1; i < LAT; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/sram_responder.sv
// On-chip stand-in for a 32-bit async SRAM: RAM storage, pipelined tristate read
// return, backdoor preload, sticky protocol-error flags and saturating access counters.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int DEPTH    = SRAM_DEPTH,
  parameter int READ_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  inout  wire  [DATA_W-1:0] SRAM_io,
  input  logic [ADDR_W-1:0] SRAM_addr,
  input  logic              Read_Signal_n,
  input  logic              Write_Signal_n,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_ready,
  output logic              bus_conflict,
  output logic              addr_oob,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // NOTE: the storage array has no reset; its contents deliberately survive Reset.
  logic [DATA_W-1:0] mem [DEPTH];

  cycle_t            cyc;
  logic              bus_oob;
  logic              init_oob;
  logic [IDX_W-1:0]  bus_idx;
  logic [IDX_W-1:0]  init_idx;
  logic              rd_load;
  logic [DATA_W-1:0] rd_data;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;

  // Reset dominates the bus: no access is recognised on a reset edge.
  assign cyc      = Reset ? CYC_IDLE : decode_cycle(Read_Signal_n, Write_Signal_n);
  assign bus_oob  = (SRAM_addr >= DEPTH_A);
  assign init_oob = (init_addr >= DEPTH_A);
  assign bus_idx  = SRAM_addr[IDX_W-1:0];
  assign init_idx = init_addr[IDX_W-1:0];

  assign init_ready = Write_Signal_n;

  // Bus write and preload are mutually exclusive through Write_Signal_n.
  always_ff @(posedge Clock) begin
    if (cyc == CYC_WRITE && !bus_oob) begin
      mem[bus_idx] <= SRAM_io;
    end else if (init_we && Write_Signal_n && !init_oob) begin
      mem[init_idx] <= init_data;
    end
  end

  // Array is read before this edge's preload lands, so a same-edge preload yields old data.
  assign rd_load = (cyc == CYC_READ);
  assign rd_data = bus_oob ? '0 : mem[bus_idx];

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (READ_LAT)
  ) u_rd_pipe (
    .Clock     (Clock),
    .Reset     (Reset),
    .in_valid  (rd_load),
    .in_data   (rd_data),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  // Never drive while the manager has the write strobe low.
  assign SRAM_io = (pipe_valid && Write_Signal_n) ? pipe_data : 'z;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus_conflict <= 1'b0;
      addr_oob     <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      case (cyc)
        CYC_CONFLICT: bus_conflict <= 1'b1;
        CYC_READ:     rd_count     <= sat_inc(rd_count);
        CYC_WRITE:    wr_count     <= sat_inc(wr_count);
        default:      ;
      endcase
      if ((cyc == CYC_READ || cyc == CYC_WRITE) && bus_oob) begin
        addr_oob <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: three instances (READ_LAT 1/3/2) share one
// stimulus stream and are compared against a cycle-indexed behavioural model.
module tb_sram_responder;
  import sram_responder_pkg::*;

  localparam int          DEPTH    = 4096;
  localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;  // undriven bus floats to pull-up

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset;
  logic [19:0] SRAM_addr;
  logic        Read_Signal_n, Write_Signal_n;
  logic        init_we;
  logic [19:0] init_addr;
  logic [31:0] init_data;
  logic        drv_en;
  logic [31:0] drv_data;

  wire [31:0] io_a, io_b, io_c;
  assign io_a = drv_en ? drv_data : 'z;
  assign io_b = drv_en ? drv_data : 'z;
  assign io_c = drv_en ? drv_data : 'z;
  for (genvar b = 0; b < 32; b++) begin : g_pull
    pullup (io_a[b]);
    pullup (io_b[b]);
    pullup (io_c[b]);
  end

  logic        init_ready_a, init_ready_b, init_ready_c;
  logic        bus_conflict_a, bus_conflict_b, bus_conflict_c;
  logic        addr_oob_a, addr_oob_b, addr_oob_c;
  logic [15:0] rd_count_a, rd_count_b, rd_count_c;
  logic [15:0] wr_count_a, wr_count_b, wr_count_c;

  sram_responder #(.DEPTH(DEPTH), .READ_LAT(1)) u_a (
    .Clock(Clock), .Reset(Reset), .SRAM_io(io_a), .SRAM_addr(SRAM_addr),
    .Read_Signal_n(Read_Signal_n), .Write_Signal_n(Write_Signal_n),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .init_ready(init_ready_a), .bus_conflict(bus_conflict_a), .addr_oob(addr_oob_a),
    .rd_count(rd_count_a), .wr_count(wr_count_a));

  sram_responder #(.DEPTH(DEPTH), .READ_LAT(3)) u_b (
    .Clock(Clock), .Reset(Reset), .SRAM_io(io_b), .SRAM_addr(SRAM_addr),
    .Read_Signal_n(Read_Signal_n), .Write_Signal_n(Write_Signal_n),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .init_ready(init_ready_b), .bus_conflict(bus_conflict_b), .addr_oob(addr_oob_b),
    .rd_count(rd_count_b), .wr_count(wr_count_b));

  sram_responder #(.DEPTH(DEPTH), .READ_LAT(2)) u_c (
    .Clock(Clock), .Reset(Reset), .SRAM_io(io_c), .SRAM_addr(SRAM_addr),
    .Read_Signal_n(Read_Signal_n), .Write_Signal_n(Write_Signal_n),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .init_ready(init_ready_c), .bus_conflict(bus_conflict_c), .addr_oob(addr_oob_c),
    .rd_count(rd_count_c), .wr_count(wr_count_c));

  // Behavioural model: memory image, per-edge read history, access totals.
  logic [31:0] mem_m [DEPTH];
  int          hist_e [8];
  logic        hist_v [8];
  logic [31:0] hist_d [8];
  int          cyc_n, last_rst, n_rd, n_wr;
  logic        m_conf, m_oob;
  int          checks, failures;

  // Expected bus value in the window after the most recent edge for a given latency.
  function automatic logic [31:0] exp_io(input int lat);
    int m;
    int idx;
    m   = cyc_n - lat + 1;
    idx = m & 7;
    if (!Write_Signal_n) return drv_data;
    if (m > last_rst && hist_e[idx] == m && hist_v[idx]) return hist_d[idx];
    return RELEASED;
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
    return (n >= 65535) ? 16'hFFFF : 16'(n);
  endfunction

  task automatic step(input logic rd_n, input logic wr_n, input logic [19:0] a,
                      input logic [31:0] d, input logic rst, input logic iwe,
                      input logic [19:0] ia, input logic [31:0] idata);
    int  idx;
    logic oob;
    Reset = rst; Read_Signal_n = rd_n; Write_Signal_n = wr_n; SRAM_addr = a;
    drv_en = !wr_n; drv_data = d; init_we = iwe; init_addr = ia; init_data = idata;
    @(posedge Clock);
    cyc_n++;
    idx = cyc_n & 7;
    hist_e[idx] = cyc_n;
    hist_v[idx] = 1'b0;
    if (rst) begin
      last_rst = cyc_n; n_rd = 0; n_wr = 0; m_conf = 1'b0; m_oob = 1'b0;
    end else begin
      oob = (a >= DEPTH);
      if (!rd_n && !wr_n) begin
        m_conf = 1'b1;
      end else if (!rd_n) begin
        hist_v[idx] = 1'b1;
        hist_d[idx] = oob ? 32'h0 : mem_m[a[11:0]];
        n_rd++;
        if (oob) m_oob = 1'b1;
      end else if (!wr_n) begin
        n_wr++;
        if (oob) m_oob = 1'b1;
        else mem_m[a[11:0]] = d;
      end
    end
    if (iwe && wr_n && ia < DEPTH) mem_m[ia[11:0]] = idata;
    @(negedge Clock);
  endtask

  task automatic bus(input logic rd_n, input logic wr_n, input logic [19:0] a,
                     input logic [31:0] d);
    step(rd_n, wr_n, a, d, 1'b0, 1'b0, 20'd0, 32'd0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 20'd0, 32'd0, 1'b1, 1'b0, 20'd0, 32'd0);
    step(1'b1, 1'b1, 20'd0, 32'd0, 1'b1, 1'b0, 20'd0, 32'd0);
    bus(1'b1, 1'b1, 20'd0, 32'd0);
    checks++; if (io_a !== RELEASED) begin failures++; $display("FAIL reset_io_a: got %h want %h", io_a, RELEASED); end
    checks++; if (io_b !== RELEASED) begin failures++; $display("FAIL reset_io_b: got %h want %h", io_b, RELEASED); end
    checks++; if (io_c !== RELEASED) begin failures++; $display("FAIL reset_io_c: got %h want %h", io_c, RELEASED); end
    checks++; if (bus_conflict_a !== 1'b0) begin failures++; $display("FAIL reset_conflict: got %b want 0", bus_conflict_a); end
    checks++; if (addr_oob_a !== 1'b0) begin failures++; $display("FAIL reset_oob: got %b want 0", addr_oob_a); end
    checks++; if (rd_count_a !== 16'h0) begin failures++; $display("FAIL reset_rd_count: got %h want 0", rd_count_a); end
    checks++; if (wr_count_a !== 16'h0) begin failures++; $display("FAIL reset_wr_count: got %h want 0", wr_count_a); end
    checks++; if (init_ready_a !== 1'b1) begin failures++; $display("FAIL reset_init_ready: got %b want 1", init_ready_a); end
  endtask

  task automatic preload_all();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b1, 20'd0, 32'd0, 1'b0, 1'b1, 20'(i),
           (i == 5) ? 32'hDEAD_BEEF : ($urandom & 32'h7FFF_FFFF));
    end
  endtask

  task automatic test_preload_read();
    bus(1'b0, 1'b1, 20'd5, 32'd0);
    checks++; if (io_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL preload_read_a: got %h want %h", io_a, 32'hDEAD_BEEF); end
    checks++; if (io_c !== RELEASED) begin failures++; $display("FAIL preload_read_c_early: got %h want %h", io_c, RELEASED); end
    bus(1'b1, 1'b1, 20'd0, 32'd0);
    checks++; if (io_a !== RELEASED) begin failures++; $display("FAIL preload_release_a: got %h want %h", io_a, RELEASED); end
    checks++; if (io_c !== 32'hDEAD_BEEF) begin failures++; $display("FAIL preload_read_c: got %h want %h", io_c, 32'hDEAD_BEEF); end
    checks++; if (rd_count_a !== 16'd1) begin failures++; $display("FAIL preload_rd_count: got %0d want 1", rd_count_a); end
    bus(1'b1, 1'b1, 20'd0, 32'd0);
    checks++; if (io_b !== 32'hDEAD_BEEF) begin failures++; $display("FAIL preload_read_b: got %h want %h", io_b, 32'hDEAD_BEEF); end
    bus(1'b1, 1'b1, 20'd0, 32'd0);
    checks++; if (io_b !== RELEASED) begin failures++; $display("FAIL preload_release_b: got %h want %h", io_b, RELEASED); end
  endtask

  task automatic test_write_read();
    bus(1'b1, 1'b0, 20'd7, 32'h0000_1234);
    checks++; if (wr_count_a !== 16'd1) begin failures++; $display("FAIL wr_count_one: got %0d want 1", wr_count_a); end
    checks++; if (io_a !== exp_io(1)) begin failures++; $display("FAIL write_bus_a: got %h want %h", io_a, exp_io(1)); end
    bus(1'b0, 1'b1, 20'd7, 32'd0);
    checks++; if (io_a !== 32'h0000_1234) begin failures++; $display("FAIL raw_read_a: got %h want %h", io_a, 32'h0000_1234); end
    checks++; if (io_b !== RELEASED) begin failures++; $display("FAIL raw_b_edge0: got %h want %h", io_b, RELEASED); end
    bus(1'b1, 1'b1, 20'd0, 32'd0);
    checks++; if (io_b !== RELEASED) begin failures++; $display("FAIL raw_b_edge1: got %h want %h", io_b, RELEASED); end
    bus(1'b1, 1'b1, 20'd0, 32'd0);
    checks++; if (io_b !== 32'h0000_1234) begin failures++; $display("FAIL raw_b_edge2: got %h want %h", io_b, 32'h0000_1234); end
    bus(1'b1, 1'b1, 20'd0, 32'd0);
    checks++; if (io_b !== RELEASED) begin failures++; $display("FAIL raw_b_edge3: got %h want %h", io_b, RELEASED); end
  endtask

  task automatic test_conflict();
    bus(1'b0, 1'b0, 20'd7, 32'h0000_FFFF);
    checks++; if (bus_conflict_a !== 1'b1) begin failures++; $display("FAIL conflict_flag: got %b want 1", bus_conflict_a); end
    checks++; if (rd_count_a !== exp_cnt(n_rd)) begin failures++; $display("FAIL conflict_rd_count: got %0d want %0d", rd_count_a, exp_cnt(n_rd)); end
    checks++; if (wr_count_a !== exp_cnt(n_wr)) begin failures++; $display("FAIL conflict_wr_count: got %0d want %0d", wr_count_a, exp_cnt(n_wr)); end
    bus(1'b0, 1'b1, 20'd7, 32'd0);
    checks++; if (io_a !== 32'h0000_1234) begin failures++; $display("FAIL conflict_mem7: got %h want %h", io_a, 32'h0000_1234); end
    for (int i = 0; i < 3; i++) bus(1'b1, 1'b1, 20'd0, 32'd0);
    checks++; if (bus_conflict_a !== 1'b1) begin failures++; $display("FAIL conflict_sticky: got %b want 1", bus_conflict_a); end
  endtask

  task automatic test_oob();
    bus(1'b0, 1'b1, 20'(DEPTH + 1), 32'd0);
    checks++; if (io_a !== 32'h0) begin failures++; $display("FAIL oob_read_data: got %h want 0", io_a); end
    checks++; if (addr_oob_a !== 1'b1) begin failures++; $display("FAIL oob_flag: got %b want 1", addr_oob_a); end
    checks++; if (rd_count_a !== exp_cnt(n_rd)) begin failures++; $display("FAIL oob_rd_count: got %0d want %0d", rd_count_a, exp_cnt(n_rd)); end
    bus(1'b1, 1'b0, 20'(DEPTH + 1), 32'hCAFE_F00D);
    bus(1'b0, 1'b1, 20'd1, 32'd0);
    checks++; if (io_a !== mem_m[1]) begin failures++; $display("FAIL oob_no_alias: got %h want %h", io_a, mem_m[1]); end
    checks++; if (wr_count_a !== exp_cnt(n_wr)) begin failures++; $display("FAIL oob_wr_count: got %0d want %0d", wr_count_a, exp_cnt(n_wr)); end
  endtask

  task automatic test_preload_concurrent();
    logic [31:0] old9;
    old9 = mem_m[9];
    step(1'b0, 1'b1, 20'd9, 32'd0, 1'b0, 1'b1, 20'd9, 32'h1357_2468);
    checks++; if (io_a !== old9) begin failures++; $display("FAIL concurrent_old: got %h want %h", io_a, old9); end
    bus(1'b0, 1'b1, 20'd9, 32'd0);
    checks++; if (io_a !== 32'h1357_2468) begin failures++; $display("FAIL concurrent_new: got %h want %h", io_a, 32'h1357_2468); end
    checks++; if (rd_count_a !== exp_cnt(n_rd)) begin failures++; $display("FAIL concurrent_rd_count: got %0d want %0d", rd_count_a, exp_cnt(n_rd)); end
  endtask

  task automatic test_reset_midread();
    bus(1'b0, 1'b1, 20'd11, 32'd0);
    checks++; if (io_a !== mem_m[11]) begin failures++; $display("FAIL midread_a: got %h want %h", io_a, mem_m[11]); end
    step(1'b1, 1'b1, 20'd0, 32'd0, 1'b1, 1'b0, 20'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (io_c !== RELEASED) begin failures++; $display("FAIL midread_c_%0d: got %h want %h", i, io_c, RELEASED); end
      checks++; if (io_b !== RELEASED) begin failures++; $display("FAIL midread_b_%0d: got %h want %h", i, io_b, RELEASED); end
      bus(1'b1, 1'b1, 20'd0, 32'd0);
    end
    checks++; if (rd_count_a !== 16'd0) begin failures++; $display("FAIL midread_rd_count: got %0d want 0", rd_count_a); end
    checks++; if (bus_conflict_a !== 1'b0) begin failures++; $display("FAIL midread_conflict: got %b want 0", bus_conflict_a); end
    checks++; if (addr_oob_a !== 1'b0) begin failures++; $display("FAIL midread_oob: got %b want 0", addr_oob_a); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [19:0] a, ia;
      logic        rd_n, wr_n, rst, iwe;
      r  = $urandom_range(0, 99);
      a  = ($urandom_range(0, 9) == 0) ? 20'(DEPTH + $urandom_range(0, 100)) : 20'($urandom_range(0, 63));
      ia = ($urandom_range(0, 9) == 0) ? 20'(DEPTH + $urandom_range(0, 100)) : 20'($urandom_range(0, 63));
      rd_n = !(r < 40 || (r >= 70 && r < 75));
      wr_n = !(r >= 40 && r < 75);
      rst  = (r >= 75 && r < 78);
      iwe  = ($urandom_range(0, 4) == 0);
      step(rd_n, wr_n, a, $urandom & 32'h7FFF_FFFF, rst, iwe, ia, $urandom & 32'h7FFF_FFFF);
      checks++; if (io_a !== exp_io(1)) begin failures++; $display("FAIL rand_io_a[%0d]: got %h want %h", i, io_a, exp_io(1)); end
      checks++; if (io_b !== exp_io(3)) begin failures++; $display("FAIL rand_io_b[%0d]: got %h want %h", i, io_b, exp_io(3)); end
      checks++; if (io_c !== exp_io(2)) begin failures++; $display("FAIL rand_io_c[%0d]: got %h want %h", i, io_c, exp_io(2)); end
      checks++; if (rd_count_a !== exp_cnt(n_rd)) begin failures++; $display("FAIL rand_rd_count[%0d]: got %0d want %0d", i, rd_count_a, exp_cnt(n_rd)); end
      checks++; if (wr_count_a !== exp_cnt(n_wr)) begin failures++; $display("FAIL rand_wr_count[%0d]: got %0d want %0d", i, wr_count_a, exp_cnt(n_wr)); end
      checks++; if (bus_conflict_a !== m_conf) begin failures++; $display("FAIL rand_conflict[%0d]: got %b want %b", i, bus_conflict_a, m_conf); end
      checks++; if (addr_oob_a !== m_oob) begin failures++; $display("FAIL rand_oob[%0d]: got %b want %b", i, addr_oob_a, m_oob); end
      checks++; if (init_ready_a !== Write_Signal_n) begin failures++; $display("FAIL rand_init_ready[%0d]: got %b want %b", i, init_ready_a, Write_Signal_n); end
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b1, 20'd0, 32'd0, 1'b1, 1'b0, 20'd0, 32'd0);
    for (int i = 1; i <= 70000; i++) begin
      bus(1'b0, 1'b1, 20'($urandom_range(0, 63)), 32'd0);
      checks++; if (io_a !== exp_io(1)) begin failures++; $display("FAIL sat_io_a[%0d]: got %h want %h", i, io_a, exp_io(1)); end
      if (i == 65534 || i == 65535 || i == 70000) begin
        checks++; if (rd_count_a !== exp_cnt(n_rd)) begin failures++; $display("FAIL sat_rd_count[%0d]: got %h want %h", i, rd_count_a, exp_cnt(n_rd)); end
      end
    end
    checks++; if (rd_count_b !== 16'hFFFF) begin failures++; $display("FAIL sat_rd_count_b: got %h want %h", rd_count_b, 16'hFFFF); end
    checks++; if (wr_count_a !== 16'h0) begin failures++; $display("FAIL sat_wr_count: got %h want 0", wr_count_a); end
  endtask

  initial begin
    checks = 0; failures = 0;
    cyc_n = 0; last_rst = -1; n_rd = 0; n_wr = 0; m_conf = 1'b0; m_oob = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hist_e[i] = -100; hist_v[i] = 1'b0; hist_d[i] = '0;
    end
    Reset = 1'b1; Read_Signal_n = 1'b1; Write_Signal_n = 1'b1; SRAM_addr = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0; drv_en = 1'b0; drv_data = '0;
    @(negedge Clock);
    test_reset();
    preload_all();
    test_preload_read();
    test_write_read();
    test_conflict();
    test_oob();
    test_preload_concurrent();
    test_reset_midread();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
